chunked_adder: RTL and testbench
================================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001: Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002: Parameter CHUNK, default 4, bits added per clock cycle.
REQ-003: The block SHALL require WIDTH to be an exact multiple of CHUNK, and both SHALL be >= 1.
REQ-004: The block SHALL define N = WIDTH/CHUNK as the number of compute cycles.
REQ-005: clk  input  1  sole clock, rising-edge active.
REQ-006: rst  input  1  synchronous, active-high reset.
REQ-007: start  input  1  request to add; sampled on rising edge of clk.
REQ-008: a  input  WIDTH  operand A.
REQ-009: b  input  WIDTH  operand B.
REQ-010: cin  input  1  carry-in to bit 0.
REQ-011: ready  output  1  high when start will be accepted.
REQ-012: busy  output  1  high while an addition is in progress.
REQ-013: done  output  1  one-cycle pulse marking a valid result.
REQ-014: s  output  WIDTH  sum, registered.
REQ-015: cout  output  1  unsigned carry-out of bit WIDTH-1.
REQ-016: ovf  output  1  two's-complement signed overflow flag.

Function
REQ-017: The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018: ready SHALL be high in IDLE and DONE, and low in RUN.
REQ-019: busy SHALL be high only in RUN.
REQ-020: done SHALL be high only in DONE.
REQ-021: In IDLE or DONE, start=1 at an edge SHALL:
  - latch a, b and cin into internal registers;
  - clear the chunk index to 0;
  - move the FSM to RUN.
REQ-022: In DONE, start=0 at an edge SHALL move the FSM to IDLE.
REQ-023: In IDLE, start=0 SHALL keep the FSM in IDLE.
REQ-024: start while in RUN SHALL be ignored; a, b and cin SHALL NOT be re-latched.
REQ-025: Each RUN edge SHALL add chunk k (bits k*CHUNK+CHUNK-1 down to k*CHUNK) of the latched operands plus the running carry.
  - The running carry SHALL initialise to the latched cin.
  - The CHUNK-bit result SHALL be written into bits k*CHUNK+CHUNK-1 down to k*CHUNK of an internal result register.
  - The chunk index SHALL then increment.
REQ-026: At the RUN edge processing chunk N-1, the block SHALL move to DONE and update s, cout and ovf from the completed sum.
REQ-027: done SHALL therefore rise exactly N cycles after the edge that accepted start, and SHALL last exactly one cycle.
REQ-028: s, cout and ovf SHALL hold their value until the next completion or reset; partial sums SHALL never appear on s.
REQ-029: cout SHALL equal bit WIDTH of the full-precision sum a+b+cin.
REQ-030: ovf SHALL equal (carry into bit WIDTH-1) XOR cout.
REQ-031: Results SHALL be exact modulo 2^WIDTH for all operand values, including all-ones and cin=1.
REQ-032: Back-to-back operation: start=1 during DONE SHALL begin the next addition, giving one result every N+1 cycles.
REQ-033: For CHUNK=WIDTH (N=1), done SHALL rise one cycle after start is accepted.

Reset
REQ-034: At a rising edge with rst=1, the block SHALL:
  - move the FSM to IDLE;
  - clear s, cout, ovf, done and busy to 0, and set ready to 1;
  - clear the chunk index, the carry and the latched operands to 0.
REQ-035: rst SHALL take priority over start in the same cycle.
REQ-036: rst asserted during RUN SHALL abort the addition; no done pulse SHALL follow.

Verification (WIDTH=16, CHUNK=4, so N=4)
REQ-037: a=0x0001, b=0x0001, cin=0, start pulse:
  - busy high for 4 cycles;
  - done high on the 4th cycle after acceptance;
  - s=0x0002, cout=0, ovf=0.
REQ-038: Carry and overflow cases:
  - a=0x0001, b=0x0001, cin=1 -> s=0x0003, cout=0, ovf=0.
  - a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0.
  - a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
  - a=0x8000, b=0x8000, cin=0 -> s=0x0000, cout=1, ovf=1.
REQ-039: Start at cycle 2 of RUN with a=0x1234, b=0x1111 -> start ignored; original result delivered on schedule; s unchanged by the ignored request.
REQ-040: rst=1 for one cycle mid-RUN -> IDLE next cycle, all outputs 0, ready=1, no done pulse; a new start then completes normally.
REQ-041: Back-to-back test:
  - start held high across two additions, 0x00FF+0x0001 then 0x0F0F+0xF0F0;
  - done pulses 5 cycles apart;
  - s=0x0100, then s=0xFFFF with cout=0.
REQ-042: The bench SHALL re-run REQ-038 with CHUNK=16 (done 1 cycle after acceptance) and with CHUNK=1 (done 16 cycles after acceptance), expecting identical s, cout and ovf.

Source files
------------

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder that sums WIDTH-bit operands CHUNK bits per
// clock. The carry ripples through a register between chunks. The completed
// sum, carry-out and signed-overflow flag are published together on the final
// chunk, so partial sums never reach s.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Refuse to elaborate a geometry the chunk slicing cannot represent.
    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic             load;
    logic             step;
    logic             last;

    logic [CHUNK-1:0] a_chunk [N];
    logic [CHUNK-1:0] b_chunk [N];
    logic [CHUNK-1:0] a_sel;
    logic [CHUNK-1:0] b_sel;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] res_full;
    logic             carry_into_msb;

    // A new request is taken whenever the block is not mid-addition.
    assign load = start && (state_reg != RUN);
    assign step = (state_reg == RUN);
    assign last = step && (idx_reg == LAST_IDX);

    // Slice the latched operands into chunks so the active one is a plain mux.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign a_sel = a_chunk[idx_reg];
    assign b_sel = b_chunk[idx_reg];

    // One CHUNK-wide add per cycle; the top bit becomes the next running carry.
    assign chunk_sum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry_reg};

    // Full sum as it stands after this cycle: the chunk being computed right
    // now is spliced over the stored partial result.
    generate
        for (gi = 0; gi < N; gi++) begin : g_merge
            assign res_full[gi*CHUNK +: CHUNK] =
                (idx_reg == IDX_W'(gi)) ? chunk_sum[CHUNK-1:0]
                                        : res_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Carry into the sign bit recovered from the sign-bit sum: c = a ^ b ^ s.
    assign carry_into_msb = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ res_full[WIDTH-1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: RUN lasts exactly N cycles, DONE lasts one.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, chunk index and running carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
        end else if (load) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
        end else if (step) begin
            carry_reg <= chunk_sum[CHUNK];
            idx_reg   <= last ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // Partial result store: only the chunk currently being computed is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg <= '0;
        end else if (step) begin
            for (int i = 0; i < N; i++) begin
                if (idx_reg == IDX_W'(i)) begin
                    res_reg[i*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                end
            end
        end
    end

    // Published result: updated only when the last chunk completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (last) begin
            s_reg    <= res_full;
            cout_reg <= chunk_sum[CHUNK];
            ovf_reg  <= carry_into_msb ^ chunk_sum[CHUNK];
        end
    end

    assign ready = (state_reg != RUN);
    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign s     = s_reg;
    assign cout  = cout_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: three geometries (CHUNK=4, 16, 1) checked against
// a plain-arithmetic model of unsigned and signed addition.
module tb_chunked_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    = 1'b1;
    logic        start4 = 1'b0;
    logic        startx = 1'b0;
    logic        cin    = 1'b0;
    logic [15:0] a      = '0;
    logic [15:0] b      = '0;

    logic        ready4, busy4, done4, cout4, ovf4;
    logic [15:0] s4;
    logic        ready16, busy16, done16, cout16, ovf16;
    logic [15:0] s16;
    logic        ready1, busy1, done1, cout1, ovf1;
    logic [15:0] s1;

    int errors = 0;
    int checks = 0;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin),
        .ready(ready4), .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
    );

    chunked_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .start(startx), .a(a), .b(b), .cin(cin),
        .ready(ready16), .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16)
    );

    chunked_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(startx), .a(a), .b(b), .cin(cin),
        .ready(ready1), .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
    );

    // Reference: {ovf, cout, s} from integer arithmetic on the operands.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc);
        int          sg;
        int unsigned u;
        logic        m_ovf;
        logic        m_cout;
        u      = int'(ma) + int'(mb) + int'(mc);
        sg     = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        m_cout = (u > 65535);
        m_ovf  = (sg > 32767) || (sg < -32768);
        return {m_ovf, m_cout, u[15:0]};
    endfunction

    // Launch one addition on all three adders; report per-adder latency (-1 = timeout).
    task automatic run_add(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                           output int l4, output int l16, output int l1);
        a = ta; b = tb_v; cin = tc;
        start4 = 1'b1; startx = 1'b1;
        @(negedge clk);
        start4 = 1'b0; startx = 1'b0;
        l4 = -1; l16 = -1; l1 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done4  && l4  < 0) l4  = c;
            if (done16 && l16 < 0) l16 = c;
            if (done1  && l1  < 0) l1  = c;
            if (l4 >= 0 && l16 >= 0 && l1 >= 0) break;
        end
        $display("add a=%h b=%h cin=%0d : s4=%h s16=%h s1=%h lat=%0d/%0d/%0d",
                 ta, tb_v, tc, s4, s16, s1, l4, l16, l1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready4, busy4, done4, cout4, ovf4} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 10000", {ready4, busy4, done4, cout4, ovf4});
        end
        checks++;
        if (s4 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_s got %h exp 0000", s4);
        end
        checks++;
        if ({ready16, busy16, done16, ready1, busy1, done1} !== 6'b100100) begin
            errors++;
            $display("FAIL reset_other got %b exp 100100",
                     {ready16, busy16, done16, ready1, busy1, done1});
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset applied");
    endtask

    task automatic test_basic();
        logic [17:0] exp;
        int          busy_cnt;
        exp = model(16'h0001, 16'h0001, 1'b0);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (busy4 && !done4 && !ready4) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 4) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d exp 4", busy_cnt);
        end
        @(negedge clk);
        checks++;
        if ({done4, busy4, ready4} !== 3'b101) begin
            errors++;
            $display("FAIL basic_done_flags got %b exp 101", {done4, busy4, ready4});
        end
        checks++;
        if ({ovf4, cout4, s4} !== exp) begin
            errors++;
            $display("FAIL basic_result got %h exp %h", {ovf4, cout4, s4}, exp);
        end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width got %b exp 0", done4);
        end
        $display("basic 0001+0001 s=%h", s4);
    endtask

    task automatic test_carry_table();
        logic [15:0] ta [5];
        logic [15:0] tbv [5];
        logic        tc [5];
        logic [17:0] exp;
        int          l4, l16, l1;
        ta  = '{16'h0001, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
        tbv = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h8000};
        tc  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            exp = model(ta[i], tbv[i], tc[i]);
            run_add(ta[i], tbv[i], tc[i], l4, l16, l1);
            checks++;
            if (l4 !== 4) begin
                errors++;
                $display("FAIL table%0d_lat4 got %0d exp 4", i, l4);
            end
            checks++;
            if (l16 !== 1) begin
                errors++;
                $display("FAIL table%0d_lat16 got %0d exp 1", i, l16);
            end
            checks++;
            if (l1 !== 16) begin
                errors++;
                $display("FAIL table%0d_lat1 got %0d exp 16", i, l1);
            end
            checks++;
            if ({ovf4, cout4, s4} !== exp) begin
                errors++;
                $display("FAIL table%0d_chunk4 {ovf,cout,s} got %h exp %h", i, {ovf4, cout4, s4}, exp);
            end
            checks++;
            if ({ovf16, cout16, s16} !== exp) begin
                errors++;
                $display("FAIL table%0d_chunk16 {ovf,cout,s} got %h exp %h", i, {ovf16, cout16, s16}, exp);
            end
            checks++;
            if ({ovf1, cout1, s1} !== exp) begin
                errors++;
                $display("FAIL table%0d_chunk1 {ovf,cout,s} got %h exp %h", i, {ovf1, cout1, s1}, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        logic        rc;
        logic [17:0] exp;
        int          l4, l16, l1;
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (i == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
            exp = model(ra, rb, rc);
            run_add(ra, rb, rc, l4, l16, l1);
            checks++;
            if (l4 !== 4 || l16 !== 1 || l1 !== 16) begin
                errors++;
                $display("FAIL rand%0d_latency got %0d/%0d/%0d exp 4/1/16", i, l4, l16, l1);
            end
            checks++;
            if ({ovf4, cout4, s4} !== exp) begin
                errors++;
                $display("FAIL rand%0d_chunk4 got %h exp %h", i, {ovf4, cout4, s4}, exp);
            end
            checks++;
            if ({ovf16, cout16, s16} !== exp) begin
                errors++;
                $display("FAIL rand%0d_chunk16 got %h exp %h", i, {ovf16, cout16, s16}, exp);
            end
            checks++;
            if ({ovf1, cout1, s1} !== exp) begin
                errors++;
                $display("FAIL rand%0d_chunk1 got %h exp %h", i, {ovf1, cout1, s1}, exp);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [15:0] prev;
        logic [17:0] exp;
        int          done_at, extra_done;
        logic        s_stable;
        logic [15:0] s_done;
        prev = s4;
        exp  = model(16'h0101, 16'h0202, 1'b0);
        a = 16'h0101; b = 16'h0202; cin = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        done_at = -1; extra_done = 0; s_stable = 1'b1; s_done = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start4 = 1'b1; a = 16'h1234; b = 16'h1111;
            end else if (c == 3) begin
                start4 = 1'b0;
            end
            if (c < 4 && s4 !== prev) s_stable = 1'b0;
            if (done4) begin
                if (done_at < 0) begin
                    done_at = c; s_done = s4;
                end else begin
                    extra_done++;
                end
            end
        end
        checks++;
        if (s_stable !== 1'b1) begin
            errors++;
            $display("FAIL ignored_s_hold got changed exp %h held", prev);
        end
        checks++;
        if (done_at !== 4) begin
            errors++;
            $display("FAIL ignored_done_time got %0d exp 4", done_at);
        end
        checks++;
        if (s_done !== exp[15:0]) begin
            errors++;
            $display("FAIL ignored_result got %h exp %h", s_done, exp[15:0]);
        end
        checks++;
        if (extra_done !== 0) begin
            errors++;
            $display("FAIL ignored_extra_done got %0d exp 0", extra_done);
        end
        $display("ignored-start run s=%h done_at=%0d", s_done, done_at);
    endtask

    task automatic test_mid_run_reset();
        int          stray, done_at;
        logic [17:0] exp;
        a = 16'h4321; b = 16'h1111; cin = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ready4, busy4, done4, cout4, ovf4} !== 5'b10000 || s4 !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_state got flags=%b s=%h exp flags=10000 s=0000",
                     {ready4, busy4, done4, cout4, ovf4}, s4);
        end
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done4) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midreset_no_done got %0d pulses exp 0", stray);
        end
        exp = model(16'h0010, 16'h0020, 1'b1);
        a = 16'h0010; b = 16'h0020; cin = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        done_at = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done4 && done_at < 0) done_at = c;
            if (done_at >= 0) break;
        end
        checks++;
        if (done_at !== 4 || {ovf4, cout4, s4} !== exp) begin
            errors++;
            $display("FAIL midreset_restart got lat=%0d res=%h exp lat=4 res=%h",
                     done_at, {ovf4, cout4, s4}, exp);
        end
        $display("mid-run reset then restart s=%h", s4);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          d1, d2, ndone;
        logic [16:0] r1, r2;
        logic [17:0] e1, e2;
        logic        busy_at5;
        e1 = model(16'h00FF, 16'h0001, 1'b0);
        e2 = model(16'h0F0F, 16'hF0F0, 1'b0);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start4 = 1'b1;
        @(negedge clk);
        d1 = -1; d2 = -1; ndone = 0; r1 = '0; r2 = '0; busy_at5 = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin a = 16'h0F0F; b = 16'hF0F0; end
            if (c == 5) busy_at5 = busy4;
            if (done4) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = c; r1 = {cout4, s4};
                end else if (d2 < 0) begin
                    d2 = c; r2 = {cout4, s4}; start4 = 1'b0;
                end
            end
        end
        start4 = 1'b0;
        checks++;
        if (d1 !== 4 || d2 !== 9) begin
            errors++;
            $display("FAIL b2b_done_times got %0d,%0d exp 4,9", d1, d2);
        end
        checks++;
        if (r1 !== e1[16:0]) begin
            errors++;
            $display("FAIL b2b_first got %h exp %h", r1, e1[16:0]);
        end
        checks++;
        if (r2 !== e2[16:0]) begin
            errors++;
            $display("FAIL b2b_second got %h exp %h", r2, e2[16:0]);
        end
        checks++;
        if (ndone !== 2 || busy_at5 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pulses got n=%0d busy5=%b exp n=2 busy5=1", ndone, busy_at5);
        end
        $display("back-to-back s1=%h s2=%h at %0d,%0d", r1[15:0], r2[15:0], d1, d2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_table();
        test_random();
        test_ignored_start();
        test_mid_run_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a wait above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
